// File: rtl/counter_pkg.sv
// Board-level defaults shared by the LED pattern counter blocks.
package counter_pkg;

   localparam int CLK_HZ             = 50_000_000;
   localparam int DIV_DEFAULT        = 2_097_152;
   // 20 ms hold time at the board clock
   localparam int DEB_CYCLES_DEFAULT = CLK_HZ / 50;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw push-button -> synchronized, debounced level plus a one-cycle rise pulse.
module btn_debounce
   import counter_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise
);

   localparam int            CW       = cnt_width(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync_p0;
   logic          sync_p1;
   logic [CW-1:0] cnt;
   logic          db_prev;

   // stage 0/1: two-flop synchronizer for the asynchronous button
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= din;
         sync_p1 <= sync_p0;
      end
   end

   // stage 2: level must disagree with dout for DEB_CYCLES edges in a row
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (sync_p1 == dout) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt  <= '0;
         dout <= sync_p1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // stage 3: previous debounced level for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_prev <= 1'b0;
      end else begin
         db_prev <= dout;
      end
   end

   assign rise = dout & ~db_prev;

endmodule

// File: rtl/tick_enable_gen.sv
// RUN/STEP buttons -> run level and single-cycle tick clock-enable for the LED counters.
module tick_enable_gen
   import counter_pkg::*;
#(
   parameter int DIV        = DIV_DEFAULT,
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_run,
   input  logic btn_step,
   output logic run,
   output logic tick,
   output logic run_db,
   output logic step_db
);

   localparam int            PW       = cnt_width(DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   logic          run_rise;
   logic          step_rise;
   logic [PW-1:0] pre;
   logic          run_next;
   logic          wrap;
   logic          tick_next;
   logic          pre_count;

   if (DIV < 2) begin : g_bad_div
      $error("tick_enable_gen: DIV must be at least 2");
   end
   if (DEB_CYCLES < 1) begin : g_bad_deb
      $error("tick_enable_gen: DEB_CYCLES must be at least 1");
   end

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb_run (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_run),
      .dout (run_db),
      .rise (run_rise)
   );

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb_step (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_step),
      .dout (step_db),
      .rise (step_rise)
   );

   // A run toggle always beats a step press, and a run->stop toggle on the
   // wrap cycle swallows that period's tick.
   always_comb begin
      run_next  = run ^ run_rise;
      wrap      = run && (pre == PRE_LAST);
      pre_count = run && run_next && !wrap;
      if (run) begin
         tick_next = wrap && !run_rise;
      end else begin
         tick_next = step_rise && !run_rise;
      end
   end

   // stage 4: run level, prescaler and tick strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run  <= 1'b0;
         pre  <= '0;
         tick <= 1'b0;
      end else begin
         run  <= run_next;
         tick <= tick_next;
         if (pre_count) begin
            pre <= pre + 1'b1;
         end else begin
            pre <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tick_enable_gen.sv
// Randomized and directed bench for tick_enable_gen against a timing-rule model.
module tb_tick_enable_gen;

   localparam int DIV = 8;
   localparam int DEB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_run = 1'b0;
   logic btn_step = 1'b0;
   logic run, tick, run_db, step_db;

   tick_enable_gen #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_run  (btn_run),
      .btn_step (btn_step),
      .run      (run),
      .tick     (tick),
      .run_db   (run_db),
      .step_db  (step_db)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // model: raw button history and derived levels
   bit q_r[$];
   bit q_s[$];
   bit m_dbr, m_dbr_old, m_dbs, m_dbs_old, m_run, m_tick;
   int m_run_start;

   // observed DUT events
   int tick_q[$];
   int rdb_rise_cyc, sdb_rise_cyc, run_rise_cyc;
   logic p_run = 1'b0, p_rdb = 1'b0, p_sdb = 1'b0;

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      q_r.delete();
      q_s.delete();
      repeat (DEB + 1) begin
         q_r.push_back(1'b0);
         q_s.push_back(1'b0);
      end
      m_dbr = 0; m_dbr_old = 0; m_dbs = 0; m_dbs_old = 0;
      m_run = 0; m_tick = 0; m_run_start = 0;
   endfunction

   // A debounced level flips once the synchronized button has disagreed
   // with it for DEB consecutive samples (sync lags raw by two edges).
   function automatic bit settle(input bit q[$], input bit cur);
      for (int i = 1; i <= DEB; i++)
         if (q[q.size() - 1 - i] == cur) return cur;
      return !cur;
   endfunction

   task automatic model_edge();
      bit rr, sr;
      if (!rst) begin
         model_reset();
         return;
      end
      rr = m_dbr && !m_dbr_old;
      sr = m_dbs && !m_dbs_old;
      if (m_run) m_tick = (((cyc - m_run_start) % DIV) == 0) && !rr;
      else       m_tick = sr && !rr;
      if (rr) begin
         m_run = !m_run;
         if (m_run) m_run_start = cyc;
      end
      m_dbr_old = m_dbr;
      m_dbr     = settle(q_r, m_dbr);
      q_r.push_back(btn_run);
      void'(q_r.pop_front());
      m_dbs_old = m_dbs;
      m_dbs     = settle(q_s, m_dbs);
      q_s.push_back(btn_step);
      void'(q_s.pop_front());
   endtask

   task automatic compare_all();
      chk("run", run, m_run);
      chk("tick", tick, m_tick);
      chk("run_db", run_db, m_dbr);
      chk("step_db", step_db, m_dbs);
      if (run && !p_run)     run_rise_cyc = cyc;
      if (run_db && !p_rdb)  rdb_rise_cyc = cyc;
      if (step_db && !p_sdb) sdb_rise_cyc = cyc;
      if (tick) tick_q.push_back(cyc);
      p_run = run;
      p_rdb = run_db;
      p_sdb = step_db;
   endtask

   task automatic step_clk();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic cycles(input int n);
      repeat (n) step_clk();
   endtask

   task automatic press_run(input int len);
      btn_run = 1'b1;
      cycles(len);
      btn_run = 1'b0;
   endtask

   task automatic check_cadence(input string tag, input int start, input int n);
      chk({tag, "_count"}, (tick_q.size() >= n) ? 1 : 0, 1);
      for (int i = 0; i < n && i < tick_q.size(); i++)
         chk(tag, tick_q[i] - ((i == 0) ? start : tick_q[i-1]), DIV);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int first;
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst_run", run, 0);
      chk("rst_tick", tick, 0);

      // reset held while buttons bounce
      for (int i = 0; i < 8; i++) begin
         btn_run  = i[0];
         btn_step = !i[0];
         step_clk();
      end
      btn_run  = 1'b0;
      btn_step = 1'b0;
      cycles(2);
      rst = 1'b1;
      tick_q.delete();
      cycles(20);
      chk("no_tick_after_rst", tick_q.size(), 0);

      // short glitch is filtered
      rdb_rise_cyc = -1;
      press_run(3);
      cycles(12);
      chk("glitch_run_db", rdb_rise_cyc, -1);

      // real press, then running cadence
      t0 = cyc;
      run_rise_cyc = -1;
      tick_q.delete();
      press_run(10);
      cycles(70);
      chk("run_db_latency", rdb_rise_cyc - t0, 6);
      chk("run_latency", run_rise_cyc - rdb_rise_cyc, 1);
      check_cadence("run_period", run_rise_cyc, 5);

      // stop
      press_run(10);
      cycles(10);
      tick_q.delete();
      cycles(40);
      chk("ticks_after_stop", tick_q.size(), 0);
      chk("run_off", run, 0);

      // restart, then stop on the wrap cycle
      press_run(10);
      cycles(20);
      for (int i = 0; i < DIV && ((cyc + 7 - m_run_start) % DIV) != 0; i++) step_clk();
      tick_q.delete();
      press_run(10);
      cycles(30);
      chk("aligned_stop_ticks", tick_q.size(), 0);
      chk("aligned_stop_run", run, 0);

      // step while stopped
      sdb_rise_cyc = -1;
      tick_q.delete();
      btn_step = 1'b1;
      cycles(10);
      btn_step = 1'b0;
      cycles(20);
      chk("step_tick_count", tick_q.size(), 1);
      first = (tick_q.size() > 0) ? tick_q[0] : -1;
      chk("step_tick_latency", first - sdb_rise_cyc, 1);

      // step while running is ignored
      press_run(10);
      cycles(10);
      tick_q.delete();
      btn_step = 1'b1;
      cycles(10);
      btn_step = 1'b0;
      cycles(30);
      chk("run_step_count", (tick_q.size() >= 5) ? 1 : 0, 1);
      for (int i = 1; i < tick_q.size(); i++)
         chk("run_step_period", tick_q[i] - tick_q[i-1], DIV);

      // reset mid-count with prescaler at 5
      for (int i = 0; i < DIV && ((cyc - m_run_start) % DIV) != 5; i++) step_clk();
      rst = 1'b0;
      model_reset();
      #1;
      chk("midrst_run", run, 0);
      chk("midrst_tick", tick, 0);
      chk("midrst_run_db", run_db, 0);
      btn_run = 1'b1;
      cycles(3);
      btn_run = 1'b0;
      rst = 1'b1;
      cycles(5);
      run_rise_cyc = -1;
      tick_q.delete();
      press_run(10);
      cycles(20);
      first = (tick_q.size() > 0) ? tick_q[0] : -1;
      chk("midrst_first_tick", first - run_rise_cyc, DIV);

      // randomized buttons with occasional resets
      for (int i = 0; i < 300; i++) begin
         int len;
         len = $urandom_range(1, 14);
         if ($urandom_range(0, 3) == 0) btn_run = !btn_run;
         btn_step = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 60) == 0) begin
            rst = 1'b0;
            model_reset();
         end else begin
            rst = 1'b1;
         end
         cycles(len);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
